// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, RV32 opcodes
// and the mux-select encodings driven onto the datapath.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RFN = 2'b10;
  localparam logic [1:0] ALUOP_IFN = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  // States that hold until the memory handshake completes.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags the cycle in which the
// stall length reaches TIMEOUT (0 disables the timeout entirely).
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  // The count holds previously stalled cycles, so it never needs to exceed TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 count <= '0;
    else if (clear || !waiting || TIMEOUT == 0) count <= '0;
    else                                      count <= count + TW'(1);
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = waiting && (count == TW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32-subset control unit: Moore-style decode of the state register,
// memory outputs gated by mem_ready, stall timeout trap and retire counter.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter bit EN_JAL  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRwrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [1:0]       MemtoReg,
  output logic             trap,
  output logic [CNT_W-1:0] retired_count
);

  state_t state_q, state_d;
  logic   waiting, expired, retire;

  assign state   = state_q;
  assign waiting = is_mem_state(state_q) && !mem_ready;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .clear   (mem_ready || (state_d != state_q)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRwrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_RS2;
    PCSource    = PCSRC_ALU;
    MemtoReg    = MTR_ALUOUT;
    trap        = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRwrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        case (Op)
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = EN_JAL ? S_JAL : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (Op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = MTR_MDR;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_RFN;
        state_d = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_IFN;
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        MemtoReg = MTR_ALUOUT;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        MemtoReg = MTR_PC;
        PCWrite  = 1'b1;
        PCSource = PCSRC_ALUOUT;
        state_d  = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_TRAP;
    endcase
    // A stall that hits the limit overrides the state's own choice; expired implies !mem_ready.
    if (expired) state_d = S_TRAP;
  end

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_MEM_WB) || (state_q == S_MEM_WRITE) ||
                   (state_q == S_ALU_WB) || (state_q == S_BRANCH) || (state_q == S_JAL));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        retired_count <= '0;
    else if (retire) retired_count <= retired_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: builds the expected per-cycle trace from an
// instruction list and compares both DUT configurations against it every cycle.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LW_OP  = 7'b0000011;
  localparam logic [6:0] SW_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] BAD_OP = 7'b1111111;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       srca, reg_write, reg_dst;
    logic [1:0] aluop, srcb, pcsrc, mtr;
    logic       trap;
  } ctrl_t;

  typedef struct {
    logic [3:0]  st;
    logic [6:0]  op;
    logic        mr;
    logic [63:0] ret;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = '0;
  logic       mem_ready = 1'b0;
  bit         sel_b = 1'b0;

  int errors = 0;
  int checks = 0;

  // DUT A: narrow counter, short timeout, JAL on. DUT B: defaults but timeout off, JAL off.
  logic [3:0] a_state, b_state;
  logic a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_srca, a_rw, a_rd, a_trap;
  logic b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_srca, b_rw, b_rd, b_trap;
  logic [1:0] a_aluop, a_srcb, a_pcsrc, a_mtr, b_aluop, b_srcb, b_pcsrc, b_mtr;
  logic [2:0]  a_ret;
  logic [31:0] b_ret;

  multicycle_ctrl_fsm #(.CNT_W(3), .TIMEOUT(4), .EN_JAL(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .Op(op), .mem_ready(mem_ready), .state(a_state),
    .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
    .MemWrite(a_mwr), .IRwrite(a_irw), .ALUSrcA(a_srca), .RegWrite(a_rw),
    .RegDst(a_rd), .ALUOp(a_aluop), .ALUSrcB(a_srcb), .PCSource(a_pcsrc),
    .MemtoReg(a_mtr), .trap(a_trap), .retired_count(a_ret)
  );

  multicycle_ctrl_fsm #(.CNT_W(32), .TIMEOUT(0), .EN_JAL(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .Op(op), .mem_ready(mem_ready), .state(b_state),
    .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
    .MemWrite(b_mwr), .IRwrite(b_irw), .ALUSrcA(b_srca), .RegWrite(b_rw),
    .RegDst(b_rd), .ALUOp(b_aluop), .ALUSrcB(b_srcb), .PCSource(b_pcsrc),
    .MemtoReg(b_mtr), .trap(b_trap), .retired_count(b_ret)
  );

  always #5 clk = ~clk;

  logic [3:0]  dut_state;
  ctrl_t       dut_ctrl;
  logic [63:0] dut_ret;

  always_comb begin
    if (sel_b) begin
      dut_state = b_state;
      dut_ctrl  = {b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_srca, b_rw, b_rd,
                   b_aluop, b_srcb, b_pcsrc, b_mtr, b_trap};
      dut_ret   = {32'd0, b_ret};
    end else begin
      dut_state = a_state;
      dut_ctrl  = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_srca, a_rw, a_rd,
                   a_aluop, a_srcb, a_pcsrc, a_mtr, a_trap};
      dut_ret   = {61'd0, a_ret};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control table straight from the state descriptions.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr);
    ctrl_t c = '0;
    case (st)
      4'd1:  begin c.mem_read = 1; c.srcb = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      4'd2:  c.srcb = 2'b10;
      4'd3:  begin c.srca = 1; c.srcb = 2'b10; end
      4'd4:  begin c.mem_read = 1; c.iord = 1; end
      4'd5:  begin c.reg_write = 1; c.mtr = 2'b01; end
      4'd6:  begin c.iord = 1; c.mem_write = 1; end
      4'd7:  begin c.srca = 1; c.aluop = 2'b10; end
      4'd8:  begin c.srca = 1; c.srcb = 2'b10; c.aluop = 2'b11; end
      4'd9:  begin c.reg_write = 1; c.reg_dst = 1; end
      4'd10: begin c.srca = 1; c.aluop = 2'b01; c.pc_write_cond = 1; c.pcsrc = 2'b01; end
      4'd11: begin c.reg_write = 1; c.reg_dst = 1; c.mtr = 2'b10; c.pc_write = 1; c.pcsrc = 2'b01; end
      4'd15: c.trap = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instruction-level model: expands each instruction into its expected cycle trace.
  rec_t       exp_q[$];
  int         ret_cnt;
  bit         trapped;
  int         cur_timeout;
  bit         cur_en_jal;
  logic [6:0] cur_op;

  task automatic add(input logic [3:0] st, input logic mr);
    rec_t r;
    r.st  = st;
    r.op  = cur_op;
    r.mr  = mr;
    r.ret = sel_b ? 64'(ret_cnt) : 64'(ret_cnt % 8);
    exp_q.push_back(r);
  endtask

  task automatic mem_phase(input logic [3:0] st, input int waits);
    for (int i = 0; i < waits && !trapped; i++) begin
      add(st, 1'b0);
      if (cur_timeout != 0 && i + 1 == cur_timeout) trapped = 1'b1;
    end
    if (!trapped) add(st, 1'b1);
  endtask

  task automatic instr(input logic [6:0] opc, input int fw, input int mw);
    if (trapped) return;
    cur_op = opc;
    mem_phase(4'd1, fw);
    if (trapped) return;
    add(4'd2, 1'b1);
    case (opc)
      R_OP:   begin add(4'd7, 1'b1); add(4'd9, 1'b1); end
      I_OP:   begin add(4'd8, 1'b1); add(4'd9, 1'b1); end
      LW_OP:  begin
        add(4'd3, 1'b1);
        mem_phase(4'd4, mw);
        if (trapped) return;
        add(4'd5, 1'b1);
      end
      SW_OP:  begin
        add(4'd3, 1'b1);
        mem_phase(4'd6, mw);
        if (trapped) return;
      end
      BR_OP:  add(4'd10, 1'b1);
      JAL_OP: begin
        if (!cur_en_jal) begin trapped = 1'b1; return; end
        add(4'd11, 1'b1);
      end
      default: begin trapped = 1'b1; return; end
    endcase
    ret_cnt++;
  endtask

  task automatic trap_tail(input int n);
    for (int i = 0; i < n; i++) add(4'd15, 1'(i % 2 == 0));
  endtask

  task automatic run_q();
    rec_t r;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(negedge clk);
      rst = 1'b1;
      op = r.op;
      mem_ready = r.mr;
      #1;
      check("state", 64'(dut_state), 64'(r.st));
      check("ctrl", 64'(dut_ctrl), 64'(exp_ctrl(r.st, r.mr)));
      check("retired", dut_ret, r.ret);
    end
  endtask

  task automatic begin_seg(input bit b);
    sel_b       = b;
    cur_timeout = b ? 0 : 4;
    cur_en_jal  = !b;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    op = '0;
    #1;
    check("reset_state", 64'(dut_state), 64'd0);
    check("reset_ctrl", 64'(dut_ctrl), 64'd0);
    check("reset_retired", dut_ret, 64'd0);
    @(negedge clk);
    exp_q.delete();
    ret_cnt = 0;
    trapped = 1'b0;
    cur_op  = '0;
    add(4'd0, 1'b1);
  endtask

  task automatic pin_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // R-type, zero-wait: 0,1,2,7,9 then FETCH with one retire.
    begin_seg(1'b0);
    instr(R_OP, 0, 0);
    run_q();
    pin_cycle();
    check("pin_r_state", 64'(dut_state), 64'd1);
    check("pin_r_retired", dut_ret, 64'd1);

    // Each class once, LW stalled 3 in MEM_READ, SW stalled 2.
    begin_seg(1'b0);
    instr(I_OP, 0, 0);
    instr(LW_OP, 0, 3);
    instr(SW_OP, 0, 2);
    instr(BR_OP, 0, 0);
    instr(JAL_OP, 0, 0);
    run_q();
    pin_cycle();
    check("pin_mix_retired", dut_ret, 64'd5);

    // Store never completes: timeout to TRAP, later mem_ready ignored.
    begin_seg(1'b0);
    instr(R_OP, 0, 0);
    instr(SW_OP, 0, 100);
    trap_tail(6);
    run_q();
    pin_cycle();
    check("pin_timeout_trap", 64'(a_trap), 64'd1);
    check("pin_timeout_retired", dut_ret, 64'd1);

    // Illegal opcode from DECODE.
    begin_seg(1'b0);
    instr(BAD_OP, 0, 0);
    trap_tail(3);
    run_q();
    pin_cycle();
    check("pin_illegal_state", 64'(dut_state), 64'd15);

    // Nine branches on a 3-bit counter wrap to 1.
    begin_seg(1'b0);
    for (int i = 0; i < 9; i++) instr(BR_OP, 0, 0);
    run_q();
    pin_cycle();
    check("pin_wrap_retired", dut_ret, 64'd1);

    // Fetch stall just under the limit, then one that hits it.
    begin_seg(1'b0);
    instr(R_OP, 3, 0);
    instr(R_OP, 4, 0);
    trap_tail(3);
    run_q();

    // Timeout disabled: long stalls complete; JAL illegal when not enabled.
    begin_seg(1'b1);
    instr(R_OP, 10, 0);
    instr(LW_OP, 0, 20);
    instr(JAL_OP, 0, 0);
    trap_tail(3);
    run_q();
    pin_cycle();
    check("pin_nojal_state", 64'(dut_state), 64'd15);
    check("pin_nojal_retired", dut_ret, 64'd2);

    // Reset during a load aborts it and clears the count.
    begin_seg(1'b0);
    instr(R_OP, 0, 0);
    cur_op = LW_OP;
    add(4'd1, 1'b1);
    add(4'd2, 1'b1);
    add(4'd3, 1'b1);
    add(4'd4, 1'b0);
    add(4'd4, 1'b0);
    run_q();
    begin_seg(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
